// File: rtl/mlp_pkg.sv
// ---------------------------------------------------------------------------
// mlp_pkg
// Shared definitions for the MLP neuron datapath.
//   - Number formats: signed Q4.4 neurons/weights, signed accumulator.
//   - Neuron buffer geometry and control-bus address widths.
//   - Pipeline control struct carried alongside each MAC step.
//   - Q4.4 saturate / ReLU helpers used at write-back.
// ---------------------------------------------------------------------------
package mlp_pkg;

    localparam int DATA_W     = 8;    // Q4.4 neuron / weight width
    localparam int ACC_W      = 20;   // signed accumulator width
    localparam int FRAC       = 4;    // fractional bits in Q4.4
    localparam int NRAM_DEPTH = 64;   // neuron buffer entries
    localparam int NRAM_AW    = $clog2(NRAM_DEPTH);
    localparam int PROD_W     = 2 * DATA_W;  // full signed product (Q8.8)
    localparam int OUT_AW     = 11;   // write-back address width on the bus
    localparam int WADDR_W    = 16;   // weight index width

    localparam logic signed [DATA_W-1:0] Q44_MAX = 8'sh7F;  // +7.9375
    localparam logic signed [DATA_W-1:0] Q44_MIN = 8'sh80;  // -8.0

    // Q4.4 limits widened to accumulator width (signed extension).
    localparam logic signed [ACC_W-1:0] Q44_MAX_ACC = ACC_W'(Q44_MAX);
    localparam logic signed [ACC_W-1:0] Q44_MIN_ACC = ACC_W'(Q44_MIN);

    // Control bits that travel with a MAC step through the pipeline.
    typedef struct packed {
        logic               valid;
        logic               clr_acc;
        logic               wr;
        logic [NRAM_AW-1:0] out_addr;
    } stage_ctrl_t;

    // Rescale a Q8.8 accumulator value to Q4.4 and clamp to the Q4.4 range.
    function automatic logic [DATA_W-1:0] q44_saturate(input logic signed [ACC_W-1:0] value);
        logic signed [ACC_W-1:0] shifted;
        shifted = value >>> FRAC;
        if (shifted > Q44_MAX_ACC) begin
            return Q44_MAX;
        end else if (shifted < Q44_MIN_ACC) begin
            return Q44_MIN;
        end else begin
            return shifted[DATA_W-1:0];
        end
    endfunction

    // Rectified linear unit on a Q4.4 value.
    function automatic logic [DATA_W-1:0] q44_relu(input logic [DATA_W-1:0] value);
        return value[DATA_W-1] ? '0 : value;
    endfunction

    // Full write-back transform: rescale, saturate, then ReLU.
    function automatic logic [DATA_W-1:0] q44_sat_relu(input logic signed [ACC_W-1:0] value);
        return q44_relu(q44_saturate(value));
    endfunction

endpackage

// File: rtl/neuron_datapath_if.sv
// ---------------------------------------------------------------------------
// neuron_datapath_if
// Step bus from the control unit to the neuron datapath.
//   step_valid          one MAC step is issued this cycle
//   input_neuron_addr   neuron buffer read address for the step
//   output_neuron_addr  write-back address (low NRAM_AW bits used)
//   input_weight_addr   weight index for the step
//   reset_mult_acc      clear the accumulator, aligned to this step
//   write_neuron        last term of the neuron; write back the result
//   done_in             control unit has finished all layers
// Modports: master = control unit (drives), slave = datapath (receives).
// ---------------------------------------------------------------------------
interface neuron_datapath_if;
    import mlp_pkg::*;

    logic               step_valid;
    logic [NRAM_AW-1:0] input_neuron_addr;
    logic [OUT_AW-1:0]  output_neuron_addr;
    logic [WADDR_W-1:0] input_weight_addr;
    logic               reset_mult_acc;
    logic               write_neuron;
    logic               done_in;

    modport master (
        output step_valid, input_neuron_addr, output_neuron_addr,
               input_weight_addr, reset_mult_acc, write_neuron, done_in
    );

    modport slave (
        input  step_valid, input_neuron_addr, output_neuron_addr,
               input_weight_addr, reset_mult_acc, write_neuron, done_in
    );

endinterface

// File: rtl/neuron_ram.sv
// ---------------------------------------------------------------------------
// neuron_ram
// 64 x 8 neuron buffer: one synchronous write port, two synchronous read
// ports. A read of the address being written in the same cycle returns the
// previous contents.
//   clk, rst            clock; rst clears only the read-data registers
//   wr_en/addr/data     write port
//   dp_addr -> dp_data  datapath read port (1-cycle latency)
//   rd_addr -> rd_data  result read port (1-cycle latency)
// ---------------------------------------------------------------------------
module neuron_ram
    import mlp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [NRAM_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [NRAM_AW-1:0] dp_addr,
    output logic [DATA_W-1:0]  dp_data,
    input  logic [NRAM_AW-1:0] rd_addr,
    output logic [DATA_W-1:0]  rd_data
);

    logic [DATA_W-1:0] mem [NRAM_DEPTH];

    // NOTE: the array has no reset so it maps onto RAM macros and keeps its
    // contents across rst; only the output registers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads sample mem before this edge's write lands, giving old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_data <= '0;
            rd_data <= '0;
        end else begin
            dp_data <= mem[dp_addr];
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/neuron_datapath.sv
// ---------------------------------------------------------------------------
// neuron_datapath
// Three-stage MAC pipeline for an MLP neuron.
//   edge T   : step captured (S1); neuron RAM and weight ROM reads launched
//   edge T+1 : Q8.8 product registered (S2)
//   edge T+2 : accumulate, or rescale/saturate/ReLU and write back to NRAM
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   step                     control-unit step bus (slave modport)
//   weight_addr/weight_data  external synchronous weight ROM (1-cycle read)
//   load_en/addr/data        input-layer preload into NRAM
//   rd_addr -> rd_data       registered result read port
//   done                     sticky: all write-backs complete
//   collision                sticky: a preload lost to a write-back
// ---------------------------------------------------------------------------
module neuron_datapath
    import mlp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    neuron_datapath_if.slave     step,
    output logic [WADDR_W-1:0]   weight_addr,
    input  logic [DATA_W-1:0]    weight_data,
    input  logic                 load_en,
    input  logic [NRAM_AW-1:0]   load_addr,
    input  logic [DATA_W-1:0]    load_data,
    input  logic [NRAM_AW-1:0]   rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 done,
    output logic                 collision
);

    stage_ctrl_t              s1_ctrl;
    stage_ctrl_t              s2_ctrl;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic [DATA_W-1:0]        nram_dp_data;
    logic                     wb_en;
    logic [DATA_W-1:0]        wb_data;
    logic                     ram_wr_en;
    logic [NRAM_AW-1:0]       ram_wr_addr;
    logic [DATA_W-1:0]        ram_wr_data;
    logic [2:0]               done_sr;
    logic                     unused_out_addr_hi;

    // The ROM is addressed straight from the bus so its data lands in S1.
    assign weight_addr = step.input_weight_addr;

    // Only the low address bits select an NRAM entry.
    assign unused_out_addr_hi = ^step.output_neuron_addr[OUT_AW-1:NRAM_AW];

    // -----------------------------------------------------------------------
    // Control pipeline: flags ride two stages to meet their product.
    // New steps are refused once done is up.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_ctrl <= '0;
            s2_ctrl <= '0;
        end else begin
            s1_ctrl <= '{
                valid:    step.step_valid & ~done,
                clr_acc:  step.reset_mult_acc,
                wr:       step.write_neuron,
                out_addr: step.output_neuron_addr[NRAM_AW-1:0]
            };
            s2_ctrl <= s1_ctrl;
        end
    end

    // Product register carries no reset: it is only consumed when s2 is valid.
    always_ff @(posedge clk) begin
        prod <= signed'(nram_dp_data) * signed'(weight_data);
    end

    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign sum      = acc + prod_ext;  // wraps at ACC_W
    assign wb_en    = s2_ctrl.valid & s2_ctrl.wr;
    assign wb_data  = q44_sat_relu(sum);

    // -----------------------------------------------------------------------
    // Accumulator. A write-back or a clear both leave it at zero; a clear
    // without write-back drops that stage's product.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (s2_ctrl.valid) begin
            if (s2_ctrl.wr || s2_ctrl.clr_acc) begin
                acc <= '0;
            end else begin
                acc <= sum;
            end
        end
    end

    // -----------------------------------------------------------------------
    // NRAM write arbitration: write-back has priority over preload.
    // -----------------------------------------------------------------------
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = load_addr;
        ram_wr_data = load_data;
        if (wb_en) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = s2_ctrl.out_addr;
            ram_wr_data = wb_data;
        end else if (load_en) begin
            ram_wr_en   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            collision <= 1'b0;
        end else if (wb_en && load_en) begin
            collision <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // done: three-cycle delay lets any step issued alongside done_in drain
    // through write-back before the flag rises; then it holds until rst.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            done_sr <= '0;
            done    <= 1'b0;
        end else begin
            done_sr <= {done_sr[1:0], step.done_in};
            done    <= done | done_sr[2];
        end
    end

    neuron_ram u_nram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .dp_addr (step.input_neuron_addr),
        .dp_data (nram_dp_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: doc/neuron_datapath.md
NEURON_DATAPATH -- requirements
Module: neuron_datapath

Interface
REQ-001 Parameters: DATA_W=8, signed Q4.4 neuron and weight format; ACC_W=20, signed accumulator; FRAC=4, fractional bits; NRAM_DEPTH=64, neuron buffer entries.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 step_valid  in  1  control unit is issuing one MAC step this cycle.
REQ-005 input_neuron_addr  in  6  neuron buffer read address for this step.
REQ-006 output_neuron_addr  in  11  write-back address; only bits [5:0] are used.
REQ-007 input_weight_addr  in  16  weight index for this step.
REQ-008 reset_mult_acc  in  1  clear the accumulator, aligned to this step.
REQ-009 write_neuron  in  1  this step is the last term of the neuron; write back.
REQ-010 done_in  in  1  control unit finished all layers.
REQ-011 weight_addr  out  16  address to the external synchronous weight ROM (1-cycle read).
REQ-012 weight_data  in  8  ROM data, valid one cycle after weight_addr.
REQ-013 load_en, load_addr[5:0], load_data[7:0]  in  input-layer preload port.
REQ-014 rd_addr  in  6; rd_data  out  8  registered result read port, 1-cycle latency.
REQ-015 done  out  1  all write-backs complete; sticky until rst.
REQ-016 collision  out  1  sticky flag: a preload was dropped.

Function
REQ-017 Pipeline: inputs captured at edge T (S1). Neuron RAM read and ROM data are available in S1. Product registered at edge T+1 (S2). Accumulate/write-back at edge T+2.
REQ-018 weight_addr shall be combinationally equal to input_weight_addr.
REQ-019 step_valid, reset_mult_acc, write_neuron, output_neuron_addr[5:0] shall be delayed 2 stages so they align with their product.
REQ-020 Product: full 16-bit signed neuron*weight, sign-extended to ACC_W.
REQ-021 Aligned valid step with no flags: acc <= acc + prod (wraps at ACC_W; no saturation in the accumulator).
REQ-022 Aligned write_neuron: sum = acc + prod; result = sum >>> FRAC, saturated to [-128,127], then ReLU (negative becomes 0). Write result to NRAM[out_addr]. Set acc <= 0.
REQ-023 Aligned reset_mult_acc without write_neuron: acc <= 0; that stage's product is discarded.
REQ-024 Aligned reset_mult_acc with write_neuron: behave as REQ-022.
REQ-025 Stage with step_valid=0: no acc change and no write, whatever the flags.
REQ-026 Write-back and load_en in the same cycle: write-back wins, the load is dropped, and collision is set.
REQ-027 load_en alone: NRAM[load_addr] <= load_data on that edge.
REQ-028 Read-during-write on the same NRAM address: the read returns the old data.
REQ-029 done_in sampled at 1: done rises exactly 3 cycles later, after the pipeline drains, and holds. Later step_valid pulses are ignored while done=1.

Reset
REQ-030 rst: acc=0, all pipeline valid and flag bits=0, done=0, collision=0, rd_data=0. NRAM contents are preserved.
REQ-031 rst mid-neuron: in-flight steps are discarded, no partial write-back occurs, and operation resumes on the next step_valid.

Structure
REQ-032 Shared package mlp_pkg: DATA_W, ACC_W, FRAC, NRAM_DEPTH, Q4.4 saturate/ReLU function, max/min Q4.4 constants.
REQ-033 One sub-module, neuron_ram: 64x8, one synchronous write port and two synchronous read ports (datapath read, result read). The remainder is 120-400 lines of RTL.

Verification
REQ-034 Preload 1.0 (0x10) and 2.0 (0x20); weights 0.5 (0x08) and 0.25 (0x04); steps 2, last with write_neuron -> NRAM[out] = 0x10 (1.0) at T+2.
REQ-035 Sum of -3.0 -> written value 0x00 (ReLU).
REQ-036 Products summing to 10.0 -> written value 0x7F (saturated).
REQ-037 load_en coincident with write-back -> write-back data stored, collision=1, load value absent.
REQ-038 rst asserted after 1 of 3 steps, then a fresh 2-step neuron -> only the second neuron's value is written, acc starts from 0.
REQ-039 done_in pulse at cycle N -> done=1 at N+3, still 1 at N+10; subsequent steps cause no NRAM change.
